// File: rtl/npower_pipe_pkg.sv
// -----------------------------------------------------------------------------
// npower_pipe_pkg
// Shared pipeline definitions for the ID/EX boundary.
//   XLEN / REG_W      : datapath width and register-number width
//   alu_op_e          : ALU operation encodings carried on ALUop
//   idex_ctrl_t       : decode control bundle registered into EX
//   stage_act_e       : per-edge action of the ID/EX register
//   gate_ctrl()       : zeroes a control bundle for a non-valid slot
// -----------------------------------------------------------------------------
package npower_pipe_pkg;

    localparam int XLEN  = 64;
    localparam int REG_W = 5;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_AND   = 3'b010,
        ALU_OR    = 3'b011,
        ALU_XOR   = 3'b100,
        ALU_SLT   = 3'b101,
        ALU_SHIFT = 3'b110,
        ALU_FUNCT = 3'b111
    } alu_op_e;

    typedef struct packed {
        logic    reg_write;
        logic    alu_src;
        logic    branch;
        logic    mem_write;
        logic    mem_read;
        logic    mem_to_reg;
        alu_op_e alu_op;
    } idex_ctrl_t;

    localparam idex_ctrl_t CTRL_NONE = '{
        reg_write:  1'b0,
        alu_src:    1'b0,
        branch:     1'b0,
        mem_write:  1'b0,
        mem_read:   1'b0,
        mem_to_reg: 1'b0,
        alu_op:     ALU_ADD
    };

    // Ordered from lowest to highest priority.
    typedef enum logic [1:0] {
        ACT_LOAD   = 2'b00,
        ACT_BUBBLE = 2'b01,
        ACT_HOLD   = 2'b10,
        ACT_FLUSH  = 2'b11
    } stage_act_e;

    // An empty slot must never carry live control into EX.
    function automatic idex_ctrl_t gate_ctrl(input idex_ctrl_t ctrl, input logic valid);
        idex_ctrl_t res;
        if (valid) begin
            res = ctrl;
        end else begin
            res = CTRL_NONE;
        end
        return res;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
// Combinational load-use compare between the load sitting in EX and the
// instruction in ID. Register 0 is treated like any other register.
//   ex_valid, ex_mem_read, ex_rd : the instruction currently in EX
//   id_valid, id_rs, id_rt       : the instruction in decode
//   alu_src, mem_write           : decide whether rt is actually read
//   load_use                     : ID needs the load result next cycle
// -----------------------------------------------------------------------------
module hazard_detect
    import npower_pipe_pkg::*;
(
    input  logic             ex_valid,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             alu_src,
    input  logic             mem_write,
    output logic             load_use
);

    logic rs_hit_s;
    logic rt_hit_s;

    assign rs_hit_s = (ex_rd == id_rs);
    // rt is only a true source when the ALU uses it or a store writes it out.
    assign rt_hit_s = (ex_rd == id_rt) & (~alu_src | mem_write);
    assign load_use = ex_valid & ex_mem_read & id_valid & (rs_hit_s | rt_hit_s);

endmodule

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register with flush, back-pressure hold and load-use
// bubble insertion, plus a saturating count of inserted bubbles.
//   clk, reset (async, active-low)
//   id_*      : decoded instruction fields and controls
//   flush     : kill the ID/EX slot (branch taken)
//   ex_ready  : EX accepts the current instruction this cycle
//   ex_*      : registered instruction presented to EX
//   id_stall  : upstream must hold PC and decode slot (combinational)
//   bubble_cnt: saturating load-use bubble count
// -----------------------------------------------------------------------------
module id_ex_stage
    import npower_pipe_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rs_data,
    input  logic [XLEN-1:0]  id_rt_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             RegWrite,
    input  logic             ALUSrc,
    input  logic             Branch,
    input  logic             MemWrite,
    input  logic             MemRead,
    input  logic             MemtoReg,
    input  logic [2:0]       ALUop,
    input  logic             flush,
    input  logic             ex_ready,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rs_data,
    output logic [XLEN-1:0]  ex_rt_data,
    output logic [XLEN-1:0]  ex_imm,
    output logic [REG_W-1:0] ex_rs,
    output logic [REG_W-1:0] ex_rt,
    output logic [REG_W-1:0] ex_rd,
    output logic             ex_RegWrite,
    output logic             ex_ALUSrc,
    output logic             ex_Branch,
    output logic             ex_MemWrite,
    output logic             ex_MemRead,
    output logic             ex_MemtoReg,
    output logic [2:0]       ex_ALUop,
    output logic             id_stall,
    output logic [15:0]      bubble_cnt
);

    logic             ex_valid_r;
    logic [XLEN-1:0]  ex_pc_r;
    logic [XLEN-1:0]  ex_rs_data_r;
    logic [XLEN-1:0]  ex_rt_data_r;
    logic [XLEN-1:0]  ex_imm_r;
    logic [REG_W-1:0] ex_rs_r;
    logic [REG_W-1:0] ex_rt_r;
    logic [REG_W-1:0] ex_rd_r;
    idex_ctrl_t       ex_ctrl_r;
    logic [15:0]      bubble_cnt_r;

    idex_ctrl_t       id_ctrl_s;
    logic             load_use_s;
    logic             hold_s;
    stage_act_e       act_s;

    hazard_detect u_hazard_detect (
        .ex_valid    (ex_valid_r),
        .ex_mem_read (ex_ctrl_r.mem_read),
        .ex_rd       (ex_rd_r),
        .id_valid    (id_valid),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .alu_src     (ALUSrc),
        .mem_write   (MemWrite),
        .load_use    (load_use_s)
    );

    assign id_ctrl_s = '{
        reg_write:  RegWrite,
        alu_src:    ALUSrc,
        branch:     Branch,
        mem_write:  MemWrite,
        mem_read:   MemRead,
        mem_to_reg: MemtoReg,
        alu_op:     alu_op_e'(ALUop)
    };

    assign hold_s   = ex_valid_r & ~ex_ready;
    // A flush frees the slot, so nothing upstream needs to wait.
    assign id_stall = ~flush & (hold_s | load_use_s);

    // Resolve this edge's action: flush > hold > bubble > load.
    always_comb begin
        act_s = ACT_LOAD;
        if (flush) begin
            act_s = ACT_FLUSH;
        end else if (hold_s) begin
            act_s = ACT_HOLD;
        end else if (load_use_s) begin
            act_s = ACT_BUBBLE;
        end else begin
            act_s = ACT_LOAD;
        end
    end

    // ID/EX pipeline register; data fields are left untouched on kill/bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid_r   <= 1'b0;
            ex_pc_r      <= {XLEN{1'b0}};
            ex_rs_data_r <= {XLEN{1'b0}};
            ex_rt_data_r <= {XLEN{1'b0}};
            ex_imm_r     <= {XLEN{1'b0}};
            ex_rs_r      <= {REG_W{1'b0}};
            ex_rt_r      <= {REG_W{1'b0}};
            ex_rd_r      <= {REG_W{1'b0}};
            ex_ctrl_r    <= CTRL_NONE;
        end else begin
            case (act_s)
                ACT_FLUSH, ACT_BUBBLE: begin
                    ex_valid_r <= 1'b0;
                    ex_ctrl_r  <= CTRL_NONE;
                end
                ACT_HOLD: begin
                    ex_valid_r <= ex_valid_r;
                    ex_ctrl_r  <= ex_ctrl_r;
                end
                ACT_LOAD: begin
                    ex_valid_r   <= id_valid;
                    ex_pc_r      <= id_pc;
                    ex_rs_data_r <= id_rs_data;
                    ex_rt_data_r <= id_rt_data;
                    ex_imm_r     <= id_imm;
                    ex_rs_r      <= id_rs;
                    ex_rt_r      <= id_rt;
                    ex_rd_r      <= id_rd;
                    ex_ctrl_r    <= gate_ctrl(id_ctrl_s, id_valid);
                end
                default: begin
                    ex_valid_r <= 1'b0;
                    ex_ctrl_r  <= CTRL_NONE;
                end
            endcase
        end
    end

    // Saturating load-use bubble counter; only real bubbles count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bubble_cnt_r <= 16'h0000;
        end else if ((act_s == ACT_BUBBLE) && (bubble_cnt_r != 16'hFFFF)) begin
            bubble_cnt_r <= bubble_cnt_r + 16'h0001;
        end else begin
            bubble_cnt_r <= bubble_cnt_r;
        end
    end

    assign ex_valid    = ex_valid_r;
    assign ex_pc       = ex_pc_r;
    assign ex_rs_data  = ex_rs_data_r;
    assign ex_rt_data  = ex_rt_data_r;
    assign ex_imm      = ex_imm_r;
    assign ex_rs       = ex_rs_r;
    assign ex_rt       = ex_rt_r;
    assign ex_rd       = ex_rd_r;
    assign ex_RegWrite = ex_ctrl_r.reg_write;
    assign ex_ALUSrc   = ex_ctrl_r.alu_src;
    assign ex_Branch   = ex_ctrl_r.branch;
    assign ex_MemWrite = ex_ctrl_r.mem_write;
    assign ex_MemRead  = ex_ctrl_r.mem_read;
    assign ex_MemtoReg = ex_ctrl_r.mem_to_reg;
    assign ex_ALUop    = ex_ctrl_r.alu_op;
    assign bubble_cnt  = bubble_cnt_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
// Directed self-checking bench for id_ex_stage: reset, normal load, load-use
// bubble, rt dependency qualification, hold/flush, hold vs load-use priority,
// asynchronous reset and bubble counter saturation.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [63:0] id_pc, id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        RegWrite, ALUSrc, Branch, MemWrite, MemRead, MemtoReg;
    logic [2:0]  ALUop;
    logic        flush, ex_ready;
    logic        ex_valid;
    logic [63:0] ex_pc, ex_rs_data, ex_rt_data, ex_imm;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic        ex_RegWrite, ex_ALUSrc, ex_Branch, ex_MemWrite, ex_MemRead, ex_MemtoReg;
    logic [2:0]  ex_ALUop;
    logic        id_stall;
    logic [15:0] bubble_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_bc;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .RegWrite(RegWrite), .ALUSrc(ALUSrc), .Branch(Branch), .MemWrite(MemWrite),
        .MemRead(MemRead), .MemtoReg(MemtoReg), .ALUop(ALUop),
        .flush(flush), .ex_ready(ex_ready),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs_data(ex_rs_data),
        .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_RegWrite(ex_RegWrite), .ex_ALUSrc(ex_ALUSrc), .ex_Branch(ex_Branch),
        .ex_MemWrite(ex_MemWrite), .ex_MemRead(ex_MemRead), .ex_MemtoReg(ex_MemtoReg),
        .ex_ALUop(ex_ALUop), .id_stall(id_stall), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Operand data is derived from the PC so every load has distinct data.
    task automatic set_id(input logic v, input logic [63:0] pc, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [4:0] rd, input logic rw,
                          input logic asrc, input logic mr, input logic mw, input logic [2:0] op);
        id_valid   = v;
        id_pc      = pc;
        id_rs_data = pc + 64'h1000;
        id_rt_data = pc + 64'h2000;
        id_imm     = pc + 64'h3000;
        id_rs      = rs;
        id_rt      = rt;
        id_rd      = rd;
        RegWrite   = rw;
        ALUSrc     = asrc;
        Branch     = 1'b0;
        MemWrite   = mw;
        MemRead    = mr;
        MemtoReg   = mr;
        ALUop      = op;
    endtask

    task automatic test_reset;
        reset    = 1'b0;
        flush    = 1'b0;
        ex_ready = 1'b1;
        set_id(1'b1, 64'h55, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 3'b010);
        tick();
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", ex_valid); end
        checks++; if (ex_pc !== 64'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", ex_pc); end
        checks++; if (ex_MemRead !== 1'b0 || ex_RegWrite !== 1'b0) begin errors++; $display("FAIL reset_ctrl got %b%b exp 00", ex_MemRead, ex_RegWrite); end
        checks++; if (bubble_cnt !== 16'h0) begin errors++; $display("FAIL reset_bcnt got %h exp 0", bubble_cnt); end
        checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", id_stall); end
        set_id(1'b0, 64'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
        @(negedge clk);
        reset  = 1'b1;
        exp_bc = 16'h0000;
    endtask

    task automatic test_normal;
        set_id(1'b1, 64'h100, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1, 3'b001);
        Branch = 1'b1;
        #1;
        checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL normal_stall got %b exp 0", id_stall); end
        tick();
        checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL normal_valid got %b exp 1", ex_valid); end
        checks++; if (ex_pc !== 64'h100) begin errors++; $display("FAIL normal_pc got %h exp 100", ex_pc); end
        checks++; if (ex_RegWrite !== 1'b1 || ex_ALUop !== 3'b001) begin errors++; $display("FAIL normal_ctrl got rw=%b op=%b exp rw=1 op=001", ex_RegWrite, ex_ALUop); end
        checks++; if (ex_rs_data !== 64'h1100 || ex_rt_data !== 64'h2100 || ex_imm !== 64'h3100) begin errors++; $display("FAIL normal_data got %h %h %h exp 1100 2100 3100", ex_rs_data, ex_rt_data, ex_imm); end
        checks++; if (ex_rs !== 5'd1 || ex_rt !== 5'd2 || ex_rd !== 5'd3) begin errors++; $display("FAIL normal_regs got %0d %0d %0d exp 1 2 3", ex_rs, ex_rt, ex_rd); end
        checks++; if ({ex_ALUSrc, ex_Branch, ex_MemWrite, ex_MemRead, ex_MemtoReg} !== 5'b11100) begin errors++; $display("FAIL normal_flags got %b exp 11100", {ex_ALUSrc, ex_Branch, ex_MemWrite, ex_MemRead, ex_MemtoReg}); end
        // Non-valid slot: data copies through, control is forced to zero.
        set_id(1'b0, 64'h104, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1, 3'b111);
        tick();
        checks++; if (ex_valid !== 1'b0 || ex_pc !== 64'h104) begin errors++; $display("FAIL invalid_load got v=%b pc=%h exp v=0 pc=104", ex_valid, ex_pc); end
        checks++; if ({ex_RegWrite, ex_ALUSrc, ex_MemWrite, ex_MemRead, ex_MemtoReg, ex_ALUop} !== 8'h00) begin errors++; $display("FAIL invalid_ctrl got %b exp 00000000", {ex_RegWrite, ex_ALUSrc, ex_MemWrite, ex_MemRead, ex_MemtoReg, ex_ALUop}); end
    endtask

    task automatic test_load_use;
        set_id(1'b1, 64'h300, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000);
        tick();
        set_id(1'b1, 64'h304, 5'd5, 5'd9, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 3'b001);
        #1;
        checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %b exp 1", id_stall); end
        tick();
        exp_bc = exp_bc + 16'd1;
        checks++; if (ex_valid !== 1'b0 || ex_MemRead !== 1'b0 || ex_RegWrite !== 1'b0) begin errors++; $display("FAIL lu_bubble got v=%b mr=%b rw=%b exp 000", ex_valid, ex_MemRead, ex_RegWrite); end
        checks++; if (bubble_cnt !== exp_bc) begin errors++; $display("FAIL lu_bcnt got %h exp %h", bubble_cnt, exp_bc); end
        checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL lu_stall_once got %b exp 0", id_stall); end
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_pc !== 64'h304) begin errors++; $display("FAIL lu_reload got v=%b pc=%h exp v=1 pc=304", ex_valid, ex_pc); end
        checks++; if (bubble_cnt !== exp_bc) begin errors++; $display("FAIL lu_bcnt_hold got %h exp %h", bubble_cnt, exp_bc); end
    endtask

    task automatic test_rt_cases;
        logic [3:0] asrc_v  = 4'b1101;
        logic [3:0] mw_v    = 4'b0100;
        logic [3:0] stall_v = 4'b1110;
        logic [4:0] rs_v[4] = '{5'd2, 5'd2, 5'd2, 5'd0};
        logic [4:0] rt_v[4] = '{5'd7, 5'd7, 5'd7, 5'd3};
        logic [4:0] rd_v[4] = '{5'd7, 5'd7, 5'd7, 5'd0};
        for (int i = 0; i < 4; i++) begin
            set_id(1'b0, 64'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
            tick();
            set_id(1'b1, 64'h500 + 64'(i * 16), 5'd1, 5'd1, rd_v[i], 1'b1, 1'b1, 1'b1, 1'b0, 3'b000);
            tick();
            set_id(1'b1, 64'h508 + 64'(i * 16), rs_v[i], rt_v[i], 5'd10, 1'b1, asrc_v[i], 1'b0, mw_v[i], 3'b000);
            #1;
            checks++; if (id_stall !== stall_v[i]) begin errors++; $display("FAIL rt_stall[%0d] got %b exp %b", i, id_stall, stall_v[i]); end
            tick();
            if (stall_v[i]) exp_bc = exp_bc + 16'd1;
            checks++; if (ex_valid !== ~stall_v[i] || bubble_cnt !== exp_bc) begin errors++; $display("FAIL rt_result[%0d] got v=%b bc=%h exp v=%b bc=%h", i, ex_valid, bubble_cnt, ~stall_v[i], exp_bc); end
        end
    endtask

    task automatic test_hold_flush;
        set_id(1'b0, 64'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
        tick();
        set_id(1'b1, 64'h200, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 3'b011);
        tick();
        ex_ready = 1'b0;
        set_id(1'b1, 64'h204, 5'd4, 5'd4, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010);
        #1;
        checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL hold_stall got %b exp 1", id_stall); end
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_pc !== 64'h200 || ex_RegWrite !== 1'b1 || ex_ALUop !== 3'b011) begin errors++; $display("FAIL hold_stable got v=%b pc=%h exp v=1 pc=200", ex_valid, ex_pc); end
        flush = 1'b1;
        #1;
        checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL flush_stall got %b exp 0", id_stall); end
        tick();
        checks++; if (ex_valid !== 1'b0 || ex_RegWrite !== 1'b0 || ex_ALUop !== 3'b000) begin errors++; $display("FAIL flush_kill got v=%b rw=%b exp 00", ex_valid, ex_RegWrite); end
        flush = 1'b0;
        #1;
        checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL post_flush_stall got %b exp 0", id_stall); end
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_pc !== 64'h204) begin errors++; $display("FAIL post_flush_load got v=%b pc=%h exp v=1 pc=204", ex_valid, ex_pc); end
        checks++; if (bubble_cnt !== exp_bc) begin errors++; $display("FAIL hold_bcnt got %h exp %h", bubble_cnt, exp_bc); end
        ex_ready = 1'b1;
    endtask

    task automatic test_hold_vs_load_use;
        set_id(1'b1, 64'h600, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000);
        tick();
        ex_ready = 1'b0;
        set_id(1'b1, 64'h604, 5'd5, 5'd8, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000);
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_pc !== 64'h600 || ex_MemRead !== 1'b1 || bubble_cnt !== exp_bc) begin errors++; $display("FAIL hold_lu got v=%b pc=%h bc=%h exp v=1 pc=600 bc=%h", ex_valid, ex_pc, bubble_cnt, exp_bc); end
        ex_ready = 1'b1;
        #1;
        checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL hold_lu_stall got %b exp 1", id_stall); end
        tick();
        exp_bc = exp_bc + 16'd1;
        checks++; if (ex_valid !== 1'b0 || bubble_cnt !== exp_bc) begin errors++; $display("FAIL hold_lu_bubble got v=%b bc=%h exp v=0 bc=%h", ex_valid, bubble_cnt, exp_bc); end
        tick();
        checks++; if (ex_pc !== 64'h604 || ex_valid !== 1'b1) begin errors++; $display("FAIL hold_lu_load got pc=%h exp 604", ex_pc); end
        // Flush takes priority over a pending load-use and is not counted.
        set_id(1'b1, 64'h700, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000);
        tick();
        set_id(1'b1, 64'h704, 5'd5, 5'd8, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000);
        flush = 1'b1;
        #1;
        checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL flush_lu_stall got %b exp 0", id_stall); end
        tick();
        checks++; if (ex_valid !== 1'b0 || bubble_cnt !== exp_bc) begin errors++; $display("FAIL flush_lu got v=%b bc=%h exp v=0 bc=%h", ex_valid, bubble_cnt, exp_bc); end
        flush = 1'b0;
    endtask

    task automatic test_async_reset;
        set_id(1'b1, 64'h800, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 3'b001);
        tick();
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        exp_bc = 16'h0000;
        checks++; if (ex_valid !== 1'b0 || ex_pc !== 64'h0 || ex_RegWrite !== 1'b0) begin errors++; $display("FAIL async_rst got v=%b pc=%h exp v=0 pc=0", ex_valid, ex_pc); end
        checks++; if (bubble_cnt !== exp_bc || id_stall !== 1'b0) begin errors++; $display("FAIL async_rst_cnt got bc=%h st=%b exp 0 0", bubble_cnt, id_stall); end
        set_id(1'b1, 64'h900, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 3'b001);
        tick();
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL rst_held got %b exp 0", ex_valid); end
        @(negedge clk);
        reset = 1'b1;
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_pc !== 64'h900) begin errors++; $display("FAIL rst_release got v=%b pc=%h exp v=1 pc=900", ex_valid, ex_pc); end
    endtask

    task automatic test_saturation;
        logic [15:0] sat_exp[3] = '{16'hFFFE, 16'hFFFF, 16'hFFFF};
        set_id(1'b0, 64'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
        tick();
        // A load that depends on itself: load, bubble, load, bubble, ...
        set_id(1'b1, 64'hA00, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000);
        tick();
        tick();
        exp_bc = exp_bc + 16'd1;
        checks++; if (bubble_cnt !== exp_bc) begin errors++; $display("FAIL sat_first got %h exp %h", bubble_cnt, exp_bc); end
        // Skip the long climb: preload the counter just below saturation.
        @(negedge clk);
        force dut.bubble_cnt_r = 16'hFFFD;
        #1;
        release dut.bubble_cnt_r;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL sat_load[%0d] got %b exp 1", i, ex_valid); end
            tick();
            checks++; if (bubble_cnt !== sat_exp[i]) begin errors++; $display("FAIL sat_cnt[%0d] got %h exp %h", i, bubble_cnt, sat_exp[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_load_use();
        test_rt_cases();
        test_hold_flush();
        test_hold_vs_load_use();
        test_async_reset();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state updates on rising edge.
REQ-002 SHALL have: reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: id_valid  in  1  decode slot holds a real instruction.
REQ-004 SHALL have: id_pc  in  64  PC of decoded instruction.
REQ-005 SHALL have: id_rs_data, id_rt_data, id_imm  in  64 each  operand values, sign-extended immediate.
REQ-006 SHALL have: id_rs, id_rt, id_rd  in  5 each  source/destination register numbers.
REQ-007 SHALL have: RegWrite, ALUSrc, Branch, MemWrite, MemRead, MemtoReg  in  1 each; ALUop  in  3  decode control.
REQ-008 SHALL have: flush  in  1  branch-taken kill of the ID/EX slot.
REQ-009 SHALL have: ex_ready  in  1  execute stage accepts this cycle.
REQ-010 SHALL have: ex_valid  out  1; ex_pc, ex_rs_data, ex_rt_data, ex_imm  out  64; ex_rs, ex_rt, ex_rd  out  5; ex_RegWrite, ex_ALUSrc, ex_Branch, ex_MemWrite, ex_MemRead, ex_MemtoReg  out  1; ex_ALUop  out  3  (registered).
REQ-011 SHALL have: id_stall  out  1  upstream must hold PC and decode slot (combinational).
REQ-012 SHALL have: bubble_cnt  out  16  saturating count of load-use bubbles inserted.

Function
REQ-013 SHALL compute load_use = ex_valid & ex_MemRead & id_valid & (ex_rd==id_rs | (ex_rd==id_rt & (~ALUSrc | MemWrite))); register 0 is an ordinary register, no exclusion.
REQ-014 SHALL drive id_stall = ~flush & ((ex_valid & ~ex_ready) | load_use).
REQ-015 SHALL apply per-edge priority: flush > hold > bubble > load.
REQ-016 Flush: next ex_valid=0, all ex_ control outputs 0, regardless of ex_ready.
REQ-017 Hold (ex_valid & ~ex_ready, no flush): all ex_ outputs and ex_valid unchanged.
REQ-018 Bubble (load_use, no hold/flush): next ex_valid=0, ex_ control 0; data fields don't-care; bubble_cnt += 1, saturating at 16'hFFFF.
REQ-019 Load (otherwise): all id_ fields and controls copied to ex_ outputs; ex_valid=id_valid.
REQ-020 SHALL force ex_ control outputs to 0 whenever the loaded id_valid=0.
REQ-021 Latency: one cycle from id_ inputs to ex_ outputs when no stall.
REQ-022 A load-use stall SHALL last exactly one cycle (bubble clears ex_MemRead).
REQ-023 Simultaneous load_use and hold SHALL resolve as hold; load_use re-evaluated afterwards.
REQ-024 bubble_cnt SHALL NOT increment on flush or hold cycles.

Reset
REQ-025 While reset=0: ex_valid=0, all ex_ outputs 0, bubble_cnt=0, asynchronously.
REQ-026 id_stall SHALL read 0 during reset (follows from ex_valid=0).
REQ-027 Reset deassertion mid-stream SHALL start in the empty state; first edge after release performs a normal load.

Structure
REQ-028 Package npower_pipe_pkg SHALL hold XLEN=64, REG_W=5, ALUop encodings, and the ID/EX control bundle typedef.
REQ-029 One sub-module, hazard_detect (combinational load_use compare), SHALL be instantiated; remaining logic in id_ex_stage.

Verification
REQ-030 Normal: id_valid=1, id_pc=0x100, RegWrite=1, ALUop=3'b001 -> next edge ex_pc=0x100, ex_RegWrite=1, ex_ALUop=001, id_stall=0.
REQ-031 Load-use: EX holds MemRead=1 rd=5; ID rs=5 -> id_stall=1 one cycle, ex_valid=0 next edge, bubble_cnt=1; instruction loads the following edge.
REQ-032 rt-only dependency with ALUSrc=1, MemWrite=0, ex_rd=id_rt=7 -> id_stall=0, no bubble.
REQ-033 Hold: ex_ready=0 three cycles with ex_pc=0x200 -> ex_ outputs stable, id_stall=1; flush asserted in cycle 2 -> ex_valid=0 next edge, id_stall=0.
REQ-034 Reset mid-operation: reset=0 asynchronously while ex_valid=1 -> ex_valid=0, bubble_cnt=0 immediately, before next clk edge.
REQ-035 Saturation: force 65536 load-use bubbles -> bubble_cnt holds 16'hFFFF.
